// File: rtl/popcnt_pkg.sv
// Shared constants and state encoding for the ones-counter (sum) and its inverse (unary_expand).
// The saturation helpers let the count width grow past what WIDTH can represent.
package popcnt_pkg;

  localparam int WIDTH = 7;
  localparam int CW    = 3;
  localparam int IW    = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Compare one bit wider than the count so the test stays meaningful for any CW.
  function automatic logic count_over(input logic [CW-1:0] c);
    return {1'b0, c} > (CW+1)'(WIDTH);
  endfunction

  function automatic logic [CW-1:0] count_sat(input logic [CW-1:0] c);
    return count_over(c) ? CW'(WIDTH) : c;
  endfunction

endpackage

// File: rtl/sum.sv
// Combinational ones-counter over a WIDTH-bit vector; zero latency, no flow control.
module sum
  import popcnt_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/unary_expand.sv
// Count -> thermometer: streams WIDTH bits LSB-first, then holds the vector; out_valid 8 clocks after accept.
// Backpressure: out_valid holds until out_ready; a new count is accepted only from IDLE.
module unary_expand
  import popcnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    count,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             err
);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] vec_q;
  logic             err_q;
  logic             bit_now;

  assign bit_now   = (32'(idx) < 32'(cnt));

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) && bit_now;
  assign out_valid = (state == HOLD);
  assign out_vec   = vec_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      vec_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= count_sat(count);
            err_q <= count_over(count);
            vec_q <= '0;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          vec_q[idx] <= bit_now;
          // Park idx on the last position rather than wrapping.
          if (idx == IW'(WIDTH-1)) begin
            state <= HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_expand.sv
// Directed bench for unary_expand with a sum loopback on out_vec.
module tb_unary_expand;
  import popcnt_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    count = '0;
  logic             ser_valid;
  logic             ser_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_vec;
  logic             err;
  logic [CW-1:0]    sum_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  unary_expand dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .count     (count),
    .ser_valid (ser_valid),
    .ser_out   (ser_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .err       (err)
  );

  sum u_sum (
    .vec   (out_vec),
    .count (sum_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cnt;
    logic [6:0] vec;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full accept -> stream -> hold -> consume transaction.
  task automatic run_txn(input logic [2:0] c, input logic [6:0] exp, input string tag);
    logic [6:0] stream;
    logic       sv_ok;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    count    = c;
    tick();
    in_valid = 1'b0;
    count    = '0;
    sv_ok    = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (ser_valid !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) sv_ok = 1'b0;
      stream[k] = ser_out;
      tick();
    end
    chk({tag, "_shift_window"}, 32'(sv_ok), 32'd1);
    chk({tag, "_stream"}, 32'(stream), 32'(exp));
    chk({tag, "_out_valid_cyc8"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_vec"}, 32'(out_vec), 32'(exp));
    chk({tag, "_loopback_sum"}, 32'(sum_cnt), 32'(c));
    chk({tag, "_err"}, 32'(err), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    chk({tag, "_vec_kept"}, 32'(out_vec), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;

    tbl[0] = '{3'd4, 7'b0001111};
    tbl[1] = '{3'd0, 7'b0000000};
    tbl[2] = '{3'd7, 7'b1111111};
    tbl[3] = '{3'd1, 7'b0000001};
    tbl[4] = '{3'd2, 7'b0000011};
    tbl[5] = '{3'd3, 7'b0000111};
    tbl[6] = '{3'd5, 7'b0011111};
    tbl[7] = '{3'd6, 7'b0111111};

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();

    // Table sweep: first entry is the count=4 case, then extremes and the rest of 0..7
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].cnt, tbl[i].vec, $sformatf("tbl%0d_c%0d", i, tbl[i].cnt));
    end

    // Backpressure: count=5 held in HOLD, in_valid stays high with count=2
    in_valid = 1'b1;
    count    = 3'd5;
    tick();
    count    = 3'd2;
    repeat (7) tick();
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== 7'b0011111) ok = 1'b0;
      tick();
    end
    chk("bp_hold_stable", 32'(ok), 32'd1);
    chk("bp_sum", 32'(sum_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    count    = '0;
    chk("bp_second_accept", 32'(ser_valid), 32'd1);
    repeat (7) tick();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_vec", 32'(out_vec), 32'b0000011);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in stream cycle 3 of a count=6 transaction
    in_valid = 1'b1;
    count    = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_rst_streaming", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_idle", {29'd0, in_ready, ser_valid, out_valid}, 32'b100);
    chk("mid_rst_vec", 32'(out_vec), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid !== 1'b0 || ser_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("mid_rst_no_pulse", 32'(ok), 32'd1);

    // Handshake rules: in_valid and out_ready pulses during SHIFT are ignored
    in_valid = 1'b1;
    count    = 3'd3;
    tick();
    in_valid = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid  = (k == 1 || k == 4);
      count     = (k == 1 || k == 4) ? 3'd7 : 3'd0;
      out_ready = (k == 2 || k == 6);
      if (ser_valid !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    count     = '0;
    chk("hs_full_stream", 32'(ok), 32'd1);
    repeat (3) tick();
    chk("hs_still_hold", {30'd0, out_valid, in_ready}, 32'b10);
    chk("hs_vec", 32'(out_vec), 32'b0000111);
    chk("hs_sum", 32'(sum_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_back_idle", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
